// File: rtl/grid_arb_pkg.sv
// -----------------------------------------------------------------------------
// grid_arb_pkg
// Shared definitions for the grid input arbiter: the arbitration FSM state
// type and the default grid packet width.
// Optional feature macro used by this slice: GRID_ARB_STATS_EN.
// -----------------------------------------------------------------------------
package grid_arb_pkg;

  localparam int unsigned GRID_PACKET_WIDTH = 30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/grid_arb_stats.sv
// -----------------------------------------------------------------------------
// grid_arb_stats
// Per-source statistics: a saturating running count of forwarded reads and a
// frame register that captures the running count on each tick (the running
// count restarts from zero at the same time).
// Only present when GRID_ARB_STATS_EN is defined; without it the file is
// empty so that no stray counter module exists in the build.
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   synchronous active-low reset
//   tick       in   frame boundary pulse
//   inc        in   one forwarded read this cycle
//   frame_cnt  out  count captured at the last tick
// -----------------------------------------------------------------------------
`ifdef GRID_ARB_STATS_EN
module grid_arb_stats #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tick,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] frame_cnt
);

  logic [CNT_WIDTH-1:0] run_q;
  logic [CNT_WIDTH-1:0] frame_q;

  // Running counter with saturation, captured and cleared on tick.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run_q   <= {CNT_WIDTH{1'b0}};
      frame_q <= {CNT_WIDTH{1'b0}};
    end else if (tick) begin
      frame_q <= run_q;
      run_q   <= {CNT_WIDTH{1'b0}};
    end else if (inc && (run_q != {CNT_WIDTH{1'b1}})) begin
      run_q   <= run_q + CNT_WIDTH'(1);
    end else begin
      run_q   <= run_q;
    end
  end

  assign frame_cnt = frame_q;

endmodule
`endif

// File: rtl/grid_input_arbiter.sv
// -----------------------------------------------------------------------------
// grid_input_arbiter
// Shares the grid's single packet input between two one-cycle-latency source
// FIFOs (0: load_packet stream, 1: CSR packet FIFO). Round-robin grants with a
// bounded burst length, reads blocked during tick, returned words steered by
// the registered grant, and a sticky flag for reads requested while empty.
// Optional feature: GRID_ARB_STATS_EN adds per-source per-frame read counters;
// without it frame_cnt0/1 are constant zero.
// Ports:
//   clk, reset_n               clock, synchronous active-low reset
//   tick                       grid tick pulse
//   src{0,1}_empty/_packet     source FIFO status and read data (1-cycle latency)
//   src{0,1}_ren               read enables to the sources
//   ren_to_input_buffer        grid read request
//   input_buffer_empty         empty indication to the grid
//   packet_in                  packet to the grid
//   arb_error                  sticky protocol error
//   frame_cnt{0,1}             reads per source in the last tick frame
// -----------------------------------------------------------------------------
module grid_input_arbiter
  import grid_arb_pkg::*;
#(
  parameter int unsigned PACKET_WIDTH = GRID_PACKET_WIDTH,
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    tick,
  input  logic                    src0_empty,
  input  logic                    src1_empty,
  input  logic [PACKET_WIDTH-1:0] src0_packet,
  input  logic [PACKET_WIDTH-1:0] src1_packet,
  output logic                    src0_ren,
  output logic                    src1_ren,
  input  logic                    ren_to_input_buffer,
  output logic                    input_buffer_empty,
  output logic [PACKET_WIDTH-1:0] packet_in,
  output logic                    arb_error,
  output logic [CNT_WIDTH-1:0]    frame_cnt0,
  output logic [CNT_WIDTH-1:0]    frame_cnt1
);

  // The burst counter holds reads already done in this grant (0..MAX_BURST-1).
  localparam int unsigned BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  arb_state_e    state_q;
  logic          rr_q;
  logic [BW-1:0] burst_q;
  logic          valid_q;   // a read was forwarded last cycle
  logic          sel_q;     // source granted for that read
  logic          err_q;

  logic granted_s, gnt_sel_s, cur_empty_s, oth_empty_s;
  logic active_s, rd_s, ibe_s, leave_s, rr_empty_s, pick_s;

  // Decode the current grant into "own" and "other" source views.
  always_comb begin
    granted_s   = 1'b0;
    gnt_sel_s   = 1'b0;
    cur_empty_s = 1'b1;
    oth_empty_s = 1'b1;
    case (state_q)
      GNT0: begin
        granted_s   = 1'b1;
        gnt_sel_s   = 1'b0;
        cur_empty_s = src0_empty;
        oth_empty_s = src1_empty;
      end
      GNT1: begin
        granted_s   = 1'b1;
        gnt_sel_s   = 1'b1;
        cur_empty_s = src1_empty;
        oth_empty_s = src0_empty;
      end
      default: begin
        granted_s   = 1'b0;
        gnt_sel_s   = 1'b0;
        cur_empty_s = 1'b1;
        oth_empty_s = 1'b1;
      end
    endcase
  end

  // Reads are also held off while reset is asserted so no word is consumed
  // from a source that will never be returned.
  assign active_s = granted_s & reset_n;
  assign rd_s     = active_s & ren_to_input_buffer & ~cur_empty_s & ~tick;
  assign ibe_s    = ~active_s | cur_empty_s | tick;
  assign leave_s  = cur_empty_s | tick | (rd_s & (burst_q == BURST_LAST));

  // From IDLE, prefer the rr source and fall back to the other one.
  assign rr_empty_s = rr_q ? src1_empty : src0_empty;
  assign pick_s     = rr_empty_s ? ~rr_q : rr_q;

  assign src0_ren           = rd_s & ~gnt_sel_s;
  assign src1_ren           = rd_s &  gnt_sel_s;
  assign input_buffer_empty = ibe_s;

  // Arbitration FSM with round-robin pointer and burst counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      burst_q <= {BW{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (!tick && !(src0_empty && src1_empty)) begin
            state_q <= pick_s ? GNT1 : GNT0;
            burst_q <= {BW{1'b0}};
          end else begin
            state_q <= IDLE;
          end
        end
        GNT0, GNT1: begin
          if (leave_s) begin
            rr_q    <= ~gnt_sel_s;
            burst_q <= {BW{1'b0}};
            if (!oth_empty_s && !tick) begin
              state_q <= gnt_sel_s ? GNT0 : GNT1;
            end else begin
              state_q <= IDLE;
            end
          end else if (rd_s) begin
            burst_q <= burst_q + BW'(1);
          end else begin
            burst_q <= burst_q;
          end
        end
        default: begin
          state_q <= IDLE;
          burst_q <= {BW{1'b0}};
        end
      endcase
    end
  end

  // Return path: remember which source answers next cycle; sticky error.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      sel_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= rd_s;
      sel_q   <= gnt_sel_s;
      err_q   <= err_q | (ren_to_input_buffer & ibe_s);
    end
  end

  assign packet_in = valid_q ? (sel_q ? src1_packet : src0_packet)
                             : {PACKET_WIDTH{1'b0}};
  assign arb_error = err_q;

`ifdef GRID_ARB_STATS_EN
  grid_arb_stats #(.CNT_WIDTH(CNT_WIDTH)) u_stats0 (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick      (tick),
    .inc       (src0_ren),
    .frame_cnt (frame_cnt0)
  );

  grid_arb_stats #(.CNT_WIDTH(CNT_WIDTH)) u_stats1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick      (tick),
    .inc       (src1_ren),
    .frame_cnt (frame_cnt1)
  );
`else
  assign frame_cnt0 = {CNT_WIDTH{1'b0}};
  assign frame_cnt1 = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_grid_input_arbiter.sv
// -----------------------------------------------------------------------------
// tb_grid_input_arbiter
// Randomised and directed stimulus for grid_input_arbiter. Source FIFOs are
// queues in the bench; a transaction-level model predicts grants, reads and
// flags; predicted packets go into a scoreboard that a separate monitor
// drains against packet_in.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_grid_input_arbiter;
  localparam int PW = 30;
  localparam int MB = 4;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n = 1'b0;
  logic          tick = 1'b0;
  logic          src0_empty = 1'b1;
  logic          src1_empty = 1'b1;
  logic          ren_to_input_buffer = 1'b0;
  logic [PW-1:0] src0_packet = '0;
  logic [PW-1:0] src1_packet = '0;
  logic          src0_ren, src1_ren, input_buffer_empty, arb_error;
  logic [PW-1:0] packet_in;
  logic [CW-1:0] frame_cnt0, frame_cnt1;

  grid_input_arbiter #(.PACKET_WIDTH(PW), .MAX_BURST(MB), .CNT_WIDTH(CW)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .tick                (tick),
    .src0_empty          (src0_empty),
    .src1_empty          (src1_empty),
    .src0_packet         (src0_packet),
    .src1_packet         (src1_packet),
    .src0_ren            (src0_ren),
    .src1_ren            (src1_ren),
    .ren_to_input_buffer (ren_to_input_buffer),
    .input_buffer_empty  (input_buffer_empty),
    .packet_in           (packet_in),
    .arb_error           (arb_error),
    .frame_cnt0          (frame_cnt0),
    .frame_cnt1          (frame_cnt1)
  );

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] fifo0[$];
  logic [PW-1:0] fifo1[$];
  logic [PW-1:0] sb[$];

  // Reference model: owner -1 means nobody is granted.
  int owner = -1;
  int rr = 0;
  int burst = 0;
  bit err = 1'b0;
  int run_c[2];
  int frame_c[2];
  bit started = 1'b0;
  bit mon_pend = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void push(input int src, input int n);
    logic [PW-1:0] v;
    for (int i = 0; i < n; i++) begin
      v = PW'($urandom());
      if (src == 0) fifo0.push_back(v);
      else          fifo1.push_back(v);
    end
  endfunction

  function automatic void model_reset();
    owner = -1; rr = 0; burst = 0; err = 1'b0;
    run_c[0] = 0; run_c[1] = 0; frame_c[0] = 0; frame_c[1] = 0;
  endfunction

  // One clock cycle: drive, check combinational and registered outputs,
  // advance the model, then let the source FIFOs respond to the DUT's reads.
  task automatic cyc(input bit t, input bit g, input bit r);
    bit e0, e1, ex, eo, ibe, rd, d0, d1;
    int x;
    @(negedge clk);
    reset_n = r; tick = t; ren_to_input_buffer = g;
    src0_empty = (fifo0.size() == 0);
    src1_empty = (fifo1.size() == 0);
    #1;
    e0 = src0_empty; e1 = src1_empty; x = owner;
    ibe = 1'b1; rd = 1'b0;
    if (r && x >= 0) begin
      ex  = (x == 1) ? e1 : e0;
      ibe = ex | t;
      rd  = g & ~ex & ~t;
    end
    chk("src0_ren", 64'(src0_ren), 64'(rd && x == 0));
    chk("src1_ren", 64'(src1_ren), 64'(rd && x == 1));
    chk("input_buffer_empty", 64'(input_buffer_empty), 64'(ibe));
    if (started) begin
      chk("arb_error", 64'(arb_error), 64'(err));
`ifdef GRID_ARB_STATS_EN
      chk("frame_cnt0", 64'(frame_cnt0), 64'(frame_c[0]));
      chk("frame_cnt1", 64'(frame_cnt1), 64'(frame_c[1]));
`else
      chk("frame_cnt0", 64'(frame_cnt0), 64'd0);
      chk("frame_cnt1", 64'(frame_cnt1), 64'd0);
`endif
    end
    if (rd) sb.push_back((x == 0) ? fifo0[0] : fifo1[0]);
    d0 = src0_ren; d1 = src1_ren;
    if (!r) begin
      model_reset();
    end else begin
      if (g && ibe) err = 1'b1;
      if (t) begin
        frame_c[0] = run_c[0]; frame_c[1] = run_c[1];
        run_c[0] = 0; run_c[1] = 0;
      end else if (rd && run_c[x] < CMAX) begin
        run_c[x] = run_c[x] + 1;
      end
      if (x < 0) begin
        if (!t && !(e0 && e1)) begin
          if ((rr == 0) ? e0 : e1) owner = 1 - rr;
          else                    owner = rr;
          burst = 0;
        end
      end else begin
        ex = (x == 1) ? e1 : e0;
        eo = (x == 1) ? e0 : e1;
        if (rd) burst = burst + 1;
        if (ex || t || burst == MB) begin
          rr = 1 - x;
          owner = (!eo && !t) ? 1 - x : -1;
          burst = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    started = 1'b1;
    if (d0 && fifo0.size() > 0) src0_packet = fifo0.pop_front();
    if (d1 && fifo1.size() > 0) src1_packet = fifo1.pop_front();
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
    fifo0.delete();
    fifo1.delete();
  endtask

  // Monitor: a word is due on packet_in the cycle after any source read.
  always @(posedge clk) mon_pend <= reset_n && (src0_ren || src1_ren);

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        if (mon_pend) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL packet_in: got %0h with no word expected at %0t", packet_in, $time);
          end else begin
            chk("packet_in", 64'(packet_in), 64'(sb.pop_front()));
          end
        end else begin
          chk("packet_in_idle", 64'(packet_in), 64'd0);
        end
      end
    end
  end

  initial begin
    model_reset();
    do_reset(2);

    // Source 0 alone, five packets, continuous grid reads.
    push(0, 5);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);

    // Reset in the cycle after a read.
    do_reset(1);
    push(0, 3);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);

    // Both sources with ten packets: bursts of MB alternate.
    do_reset(1);
    push(0, 10); push(1, 10);
    for (int i = 0; i < 30; i++) cyc(1'b0, 1'b1, 1'b1);

    // Tick on the third read of a src1 burst.
    do_reset(1);
    push(0, 6); push(1, 6);
    for (int i = 0; i < 20; i++) cyc(i == 7, 1'b1, 1'b1);

    // Grid reads while idle: sticky error, no source reads.
    do_reset(1);
    cyc(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1);

    // Frame statistics: 7 + 3 reads, tick, empty frame, tick.
    do_reset(1);
    push(0, 7); push(1, 3);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);

    // Counter saturation: more reads than the counter can hold in one frame.
    do_reset(1);
    push(0, CMAX + 40);
    for (int i = 0; i < CMAX + 60; i++) cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b1);

    // Random traffic, ticks, occasional resets.
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) push(0, $urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) push(1, $urandom_range(1, 3));
      cyc($urandom_range(0, 29) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 299) != 0);
    end

    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
